// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with a stereo frame FIFO.
// bclk/lrclk arrive asynchronously and are synchronised into clk; serial
// data leaves MSB first, one bclk after each lrclk edge.
// Optional feature: define I2S_TX_UNDERRUN_REPEAT_EN to resend the last popped
// frame on underrun; by default an underrun sends zero on both channels.
module i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] s_left,
    input  logic signed [SAMPLE_WIDTH-1:0] s_right,
    output logic                          dacda,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    logic [2:0]                  bclk_sync_q, lrclk_sync_q;
    logic                        bclk_fall, lr_fall, lr_rise;
    logic [2*SAMPLE_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]            level_q;
    logic                        push, pop, fifo_empty;
    state_t                      state_q, state_d;
    logic                        load_left, load_right;
    logic                        underrun_q, underrun_d;
    logic [2*SAMPLE_WIDTH-1:0]   fallback_frame, next_frame;
    logic signed [SAMPLE_WIDTH-1:0] shift_q, hold_q;
    logic [CNT_W-1:0]            bit_cnt_q;
    logic                        dacda_q;

    // Three-flop synchronisers; stage 2 is the level, stage 2 vs 3 the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[1:0], bclk};
            lrclk_sync_q <= {lrclk_sync_q[1:0], lrclk};
        end
    end

    assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
    assign lr_fall   = lrclk_sync_q[2] & ~lrclk_sync_q[1];
    assign lr_rise   = ~lrclk_sync_q[2] & lrclk_sync_q[1];

    assign fifo_empty = (level_q == '0);
    assign s_ready    = ~reset & (level_q != LVL_FULL);
    assign push       = s_valid & s_ready;

    // Frame storage: left sample in the upper half, right in the lower half.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_left, s_right};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next channel and word-load strobes; a falling lrclk always restarts at LEFT.
    always_comb begin
        state_d    = state_q;
        load_left  = 1'b0;
        load_right = 1'b0;
        case (state_q)
            IDLE: begin
                if (lr_fall) begin
                    state_d   = LEFT;
                    load_left = 1'b1;
                end
            end
            LEFT, RIGHT: begin
                if (lr_fall) begin
                    state_d   = LEFT;
                    load_left = 1'b1;
                end else if (lr_rise) begin
                    state_d    = RIGHT;
                    load_right = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop        = load_left & ~fifo_empty;
    assign underrun_d = load_left & fifo_empty;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [2*SAMPLE_WIDTH-1:0] last_frame_q;

    // Remember the most recently popped frame for replay on underrun.
    always_ff @(posedge clk) begin
        if (reset)    last_frame_q <= '0;
        else if (pop) last_frame_q <= mem_q[rd_ptr_q];
    end

    assign fallback_frame = last_frame_q;
`else
    assign fallback_frame = '0;
`endif

    assign next_frame = pop ? mem_q[rd_ptr_q] : fallback_frame;

    // One-clk underrun strobe.
    always_ff @(posedge clk) begin
        if (reset) underrun_q <= 1'b0;
        else       underrun_q <= underrun_d;
    end

    // Word load has priority over shifting; bits leave MSB first on bclk falls
    // and the line idles low once the word is exhausted.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            hold_q    <= '0;
            bit_cnt_q <= '0;
            dacda_q   <= 1'b0;
        end else if (load_left) begin
            shift_q   <= next_frame[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
            hold_q    <= next_frame[SAMPLE_WIDTH-1:0];
            bit_cnt_q <= '0;
        end else if (load_right) begin
            shift_q   <= hold_q;
            bit_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            dacda_q <= 1'b0;
        end else if (bclk_fall) begin
            if (bit_cnt_q != CNT_DONE) begin
                dacda_q   <= shift_q[SAMPLE_WIDTH-1];
                shift_q   <= {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else begin
                dacda_q <= 1'b0;
            end
        end
    end

    assign dacda      = dacda_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized scoreboard bench for i2s_tx. The generator drives
// bclk/lrclk and frames, keeps a queue-based model of the FIFO and pushes the
// expected serial words; a bclk-driven monitor decodes dacda and compares.
module tb_i2s_tx;
    localparam int SW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [SW-1:0] word;
        int            nbits;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bclk = 1'b1;
    logic          lrclk = 1'b1;
    logic          s_valid = 1'b0;
    logic [SW-1:0] s_left = '0;
    logic [SW-1:0] s_right = '0;
    logic          s_ready, dacda, underrun;
    logic [LW-1:0] fifo_level;

    int total = 0;
    int bad = 0;

    // Reference model state
    exp_t            expq[$];
    logic [2*SW-1:0] mfifo[$];
    bit              m_active = 0;
    logic [SW-1:0]   m_hold = '0;
    logic [2*SW-1:0] m_last = '0;
    int              m_ucnt = 0;
    logic            cur_lr = 1'b1;
    bit              mon_abort = 0;
    int              ucnt = 0;

    i2s_tx #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .dacda(dacda), .underrun(underrun), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [2*SW-1:0] fallback();
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        return m_last;
`else
        return '0;
`endif
    endfunction

    task automatic model_push(input logic [SW-1:0] l, input logic [SW-1:0] r);
        if (mfifo.size() < DEPTH) mfifo.push_back({l, r});
    endtask

    task automatic model_lr_edge(input logic l, input int nbclk);
        exp_t e;
        logic [2*SW-1:0] f;
        e.nbits = (nbclk - 1 < SW) ? nbclk - 1 : SW;
        if (l == 1'b0) begin
            m_active = 1;
            if (mfifo.size() == 0) begin
                f = fallback();
                m_ucnt++;
            end else begin
                f = mfifo.pop_front();
                m_last = f;
            end
            m_hold = f[SW-1:0];
            e.word = f[2*SW-1:SW];
            expq.push_back(e);
        end else if (m_active) begin
            e.word = m_hold;
            expq.push_back(e);
        end
    endtask

    // One bclk half-period of 5 clk cycles; optional push, level check or reset pulse.
    task automatic step(input logic b, input logic l, input bit do_push, input int push_k,
                        input bit chk_lvl, input int rst_k);
        bclk  = b;
        lrclk = l;
        for (int k = 0; k < 5; k++) begin
            if (do_push && k == push_k) begin
                s_left  = SW'($urandom);
                s_right = SW'($urandom);
                s_valid = 1'b1;
                check("s_ready_push", 32'(s_ready), 32'(mfifo.size() < DEPTH));
                model_push(s_left, s_right);
            end
            if (k == rst_k) reset = 1'b1;
            @(posedge clk);
            #3;
            s_valid = 1'b0;
            if (k == rst_k) begin
                check("reset_dacda", 32'(dacda), 32'd0);
                check("reset_level", 32'(fifo_level), 32'd0);
                check("reset_ready", 32'(s_ready), 32'd0);
                reset = 1'b0;
                mfifo.delete();
                m_active = 0;
                m_last = '0;
                mon_abort = 1;
            end
        end
        if (chk_lvl) check("fifo_level", 32'(fifo_level), 32'(mfifo.size()));
    endtask

    task automatic run_half(input logic l, input int nbclk, input int push_pct,
                            input bit coincide, input int rst_i);
        if (l != cur_lr) model_lr_edge(l, nbclk);
        cur_lr = l;
        for (int i = 0; i < nbclk; i++) begin
            bit dp;
            dp = (i == nbclk / 2) && (int'($urandom_range(99)) < push_pct);
            step(1'b0, l, dp || (coincide && i == 0), (i == 0) ? 2 : 1,
                 i == nbclk / 2 + 1, (i == rst_i) ? 1 : -1);
            step(1'b1, l, 1'b0, 0, 1'b0, -1);
        end
    endtask

    task automatic push_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        check("s_ready_direct", 32'(s_ready), 32'(mfifo.size() < DEPTH));
        model_push(l, r);
        @(posedge clk);
        #3;
        s_valid = 1'b0;
    endtask

    // Serial decoder: idx 0 is the delay slot after each lrclk change.
    logic          mon_lr = 1'b1;
    int            idx = 0;
    bit            act = 0;
    bit            had_half = 0;
    exp_t          cur;
    logic [SW-1:0] acc = '0;
    logic          tail_or = 1'b0;
    logic          idle_or = 1'b0;

    always @(posedge bclk) begin
        if (lrclk !== mon_lr) begin
            if (act && cur.nbits == SW) check("tail_zero", 32'(tail_or), 32'd0);
            else if (!act && had_half) check("idle_zero", 32'(idle_or), 32'd0);
            mon_lr = lrclk;
            idx = 0;
            acc = '0;
            tail_or = 1'b0;
            idle_or = 1'b0;
            had_half = 1;
            if (expq.size() > 0) begin
                cur = expq.pop_front();
                act = 1;
            end else begin
                act = 0;
            end
        end else begin
            idx++;
        end
        if (mon_abort) begin
            mon_abort = 0;
            act = 0;
            idle_or = 1'b0;
        end
        if (act) begin
            if (idx >= 1 && idx <= cur.nbits) begin
                acc = {acc[SW-2:0], dacda};
                if (idx == cur.nbits) check("word", 32'(acc), 32'(cur.word >> (SW - cur.nbits)));
            end else if (idx > cur.nbits) begin
                tail_or = tail_or | dacda;
            end
        end else if (idx >= 1) begin
            idle_or = idle_or | dacda;
        end
    end

    // Underrun pulse counter and width check.
    logic u_prev = 1'b0;
    always @(negedge clk) begin
        if (u_prev) check("underrun_width", 32'(underrun), 32'd0);
        if (underrun) ucnt++;
        u_prev = underrun;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int u0;
        @(posedge clk);
        #3;
        repeat (3) begin
            check("ready_in_reset", 32'(s_ready), 32'd0);
            @(posedge clk);
            #3;
        end
        check("reset_level0", 32'(fifo_level), 32'd0);
        check("reset_dacda0", 32'(dacda), 32'd0);
        check("reset_underrun0", 32'(underrun), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #3;
        check("ready_after_reset", 32'(s_ready), 32'd1);

        // Known frame, then an underrun frame
        push_frame(16'hA5C3, 16'h1234);
        check("level_one", 32'(fifo_level), 32'd1);
        run_half(1'b0, 32, 0, 0, -1);
        run_half(1'b1, 32, 0, 0, -1);
        run_half(1'b0, 32, 0, 0, -1);
        run_half(1'b1, 32, 0, 0, -1);
        check("underrun_count_a", 32'(ucnt), 32'(m_ucnt));

        // Fill with s_valid held and no bclk activity
        s_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            s_left  = SW'($urandom);
            s_right = SW'($urandom);
            check("ready_fill", 32'(s_ready), 32'(mfifo.size() < DEPTH));
            model_push(s_left, s_right);
            @(posedge clk);
            #3;
        end
        s_valid = 1'b0;
        check("fill_level", 32'(fifo_level), 32'(DEPTH));
        check("fill_ready", 32'(s_ready), 32'd0);
        for (int f = 0; f < 5; f++) begin
            run_half(1'b0, 32, 0, 0, -1);
            run_half(1'b1, 32, 0, 0, -1);
        end
        check("underrun_count_b", 32'(ucnt), 32'(m_ucnt));

        // Push coinciding with pop at level 2 over 8 frames
        push_frame(SW'($urandom), SW'($urandom));
        push_frame(SW'($urandom), SW'($urandom));
        check("level_two", 32'(fifo_level), 32'd2);
        for (int f = 0; f < 8; f++) begin
            run_half(1'b0, 32, 0, 1, -1);
            check("coincide_level", 32'(fifo_level), 32'd2);
            run_half(1'b1, 32, 0, 0, -1);
        end

        // Random half lengths and random pushes
        for (int f = 0; f < 12; f++) begin
            run_half(1'b0, int'($urandom_range(32, 17)), 60, 0, -1);
            run_half(1'b1, int'($urandom_range(32, 17)), 60, 0, -1);
        end
        check("underrun_count_c", 32'(ucnt), 32'(m_ucnt));

        // Short left word of 10 bits
        push_frame(SW'($urandom), SW'($urandom));
        u0 = ucnt;
        run_half(1'b0, 11, 0, 0, -1);
        run_half(1'b1, 32, 0, 0, -1);
        check("short_no_underrun", 32'(ucnt), 32'(u0));

        // Reset in the middle of a left word, then recover
        while (mfifo.size() > 0) begin
            run_half(1'b0, 32, 0, 0, -1);
            run_half(1'b1, 32, 0, 0, -1);
        end
        push_frame(16'hA5C3, 16'h1234);
        push_frame(SW'($urandom), SW'($urandom));
        run_half(1'b0, 32, 0, 0, 9);
        run_half(1'b1, 32, 0, 0, -1);
        run_half(1'b1, 32, 100, 0, -1);
        run_half(1'b0, 32, 0, 0, -1);
        run_half(1'b1, 32, 0, 0, -1);
        run_half(1'b0, 32, 0, 0, -1);
        run_half(1'b1, 32, 0, 0, -1);

        check("underrun_count_final", 32'(ucnt), 32'(m_ucnt));
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
